// File: rtl/pc_unit_bp.sv
// PC controller for the 5-stage simpleCPU pipeline.
// Predicts beq/bne at IF with a direct-mapped BTB of 2-bit counters, resolves them in EX and takes J-type jumps in ID.
module pc_unit_bp #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [5:0]        id_op,
    input  logic [ADDR_W-1:0] id_jtarget,
    input  logic              ex_valid,
    input  logic [5:0]        ex_op,
    input  logic              ex_z,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    output logic [ADDR_W-1:0] pc,
    output logic              pred_taken,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [1:0]        Pcsrc,
    output logic              Condep
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        PCSRC_SEQ       = 2'b00,
        PCSRC_NOT_TAKEN = 2'b01,
        PCSRC_TAKEN     = 2'b10,
        PCSRC_JUMP      = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    pcsrc_e            pcsrc_d;

    logic              btb_valid_q [BTB_ENTRIES];
    logic [1:0]        btb_ctr_q   [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q   [BTB_ENTRIES];
    logic [ADDR_W-1:0] btb_tgt_q   [BTB_ENTRIES];

    // IF-side lookup on the current fetch PC
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;

    assign lk_idx     = pc_q[IDX_W+1:2];
    assign lk_tag     = pc_q[ADDR_W-1:IDX_W+2];
    assign lk_hit     = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign pred_taken = lk_hit && btb_ctr_q[lk_idx][1];

    // EX-side branch resolution
    logic is_beq, is_bne, is_br, actual, mispred, jump_take;

    assign is_beq    = ex_valid && (ex_op == OP_BEQ);
    assign is_bne    = ex_valid && (ex_op == OP_BNE);
    assign is_br     = is_beq || is_bne;
    assign actual    = (is_beq && ex_z) || (is_bne && !ex_z);
    assign mispred   = is_br && (actual != ex_pred_taken);
    assign jump_take = (id_op == OP_J) && !stall;

    // A mispredict squashes everything younger, including a jump sitting in ID.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        pc_d    = pc_q + PC_STEP;
        pcsrc_d = PCSRC_SEQ;
        if (mispred) begin
            pc_d    = actual ? ex_target : (ex_pc + PC_STEP);
            pcsrc_d = actual ? PCSRC_TAKEN : PCSRC_NOT_TAKEN;
        end else if (jump_take) begin
            pc_d    = id_jtarget;
            pcsrc_d = PCSRC_JUMP;
        end else if (stall) begin
            pc_d    = pc_q;
        end else if (pred_taken) begin
            pc_d    = btb_tgt_q[lk_idx];
        end
    end

    assign pc         = pc_q;
    assign Pcsrc      = pcsrc_d;
    assign flush_ifid = mispred || jump_take;
    assign flush_idex = mispred;
    assign Condep     = !mispred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
            pc_q <= pc_d;
        end
    end

    // BTB update path, indexed by the resolving branch's own PC
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic              wr_en;
    logic [1:0]        wr_ctr;
    logic [ADDR_W-1:0] wr_tgt;

    assign up_idx = ex_pc[IDX_W+1:2];
    assign up_tag = ex_pc[ADDR_W-1:IDX_W+2];
    assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

    always_comb begin
        wr_en  = 1'b0;
        wr_ctr = btb_ctr_q[up_idx];
        wr_tgt = btb_tgt_q[up_idx];
        if (is_br) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (actual) begin
                    wr_tgt = ex_target;
                    if (btb_ctr_q[up_idx] != CTR_STRONG_T) begin
                        wr_ctr = btb_ctr_q[up_idx] + 2'd1;
                    end
                end else if (btb_ctr_q[up_idx] != CTR_STRONG_NT) begin
                    wr_ctr = btb_ctr_q[up_idx] - 2'd1;
                end
            end else if (actual) begin
                wr_en  = 1'b1;
                wr_ctr = CTR_WEAK_T;
                wr_tgt = ex_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the BTB array is reset explicitly because a stale valid bit after reset would redirect fetch.
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_ctr_q[i]   <= CTR_WEAK_NT;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
            end
        end else if (wr_en) begin
            btb_valid_q[up_idx] <= 1'b1;
            btb_ctr_q[up_idx]   <= wr_ctr;
            btb_tag_q[up_idx]   <= up_tag;
            btb_tgt_q[up_idx]   <= wr_tgt;
        end
    end

endmodule
